// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and constants for the UART transmit buffer and neighbouring UART stages.
//   tx_buf_state_t : handshake FSM state encoding of the transmit buffer
//   UART_DBIT      : default character width used across the UART datapath
package uart_tx_buffer_pkg;

    localparam int unsigned UART_DBIT = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSend = 2'd2,
        StGap  = 2'd3
    } tx_buf_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Bundle of CPU-side write port, transmitter handshake and status for uart_tx_buffer.
//   master : driven by the CPU register decode / transmitter side (wr_en, wr_data,
//            clr_ovf, tx_done), observes tx_start/tx_data and status
//   slave  : the buffer itself, driving tx_start, tx_data, full, empty, count, busy, ovf
interface uart_tx_buffer_if #(
    parameter int unsigned DBIT  = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            wr_en;
    logic [DBIT-1:0] wr_data;
    logic            clr_ovf;
    logic            tx_done;
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            busy;
    logic            ovf;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_done,
        input  tx_start, tx_data, full, empty, count, busy, ovf
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_done,
        output tx_start, tx_data, full, empty, count, busy, ovf
    );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//   push_i     : write wdata_i; ignored while full_o
//   wdata_i    : write data
//   pop_i      : advance read pointer; ignored while empty_o
//   rdata_o    : entry at the read pointer (show-ahead)
//   count_o    : number of entries held
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module uart_tx_buffer_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Status comes straight from the registered count, so it never depends on this
    // cycle's push/pop requests.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus handshake FSM feeding the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset clearing all state
//   bus.slave  : wr_en/wr_data push bytes, clr_ovf clears the sticky overflow flag,
//                tx_done ends the current frame; tx_start/tx_data present one byte to
//                the transmitter; full/empty/count/busy/ovf report buffer status
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DBIT  = UART_DBIT,
    parameter int unsigned DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_buffer_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_buf_state_t   state_q, state_d;
    logic [DBIT-1:0] tx_data_q, tx_data_d;
    logic            ovf_q, ovf_d;

    logic            pop;
    logic            tx_start;
    logic [DBIT-1:0] fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    uart_tx_buffer_sync_fifo #(
        .WIDTH (DBIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.wr_en),
        .wdata_i (bus.wr_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; tx_done only matters while a frame is being sent.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  if (bus.tx_done) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, decoded from registered state only. GAP keeps tx_start low for one
    // cycle so back-to-back frames always present a falling edge to the transmitter.
    always_comb begin
        pop      = 1'b0;
        tx_start = 1'b0;
        unique case (state_q)
            StLoad:  pop      = 1'b1;
            StSend:  tx_start = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture the popped byte and the sticky overflow flag.
    always_comb begin
        tx_data_d = pop ? fifo_rdata : tx_data_q;
        // A dropped write outranks a clear in the same cycle.
        if (bus.wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.busy     = (state_q != StIdle) | ~fifo_empty;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer (DBIT=8, DEPTH=16).
module tb_uart_tx_buffer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    uart_tx_buffer_if #(.DBIT(8), .DEPTH(16)) bus ();

    uart_tx_buffer #(
        .DBIT  (8),
        .DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the next frame request.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.tx_start), 32'd1);
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;
        total = 0;
        bad   = 0;

        // 1. Reset held with writes attempted
        rst_n       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        bus.clr_ovf = 1'b0;
        bus.tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_empty", 32'(bus.empty), 32'd1);
            chk("rst_count", 32'(bus.count), 32'd0);
            chk("rst_start", 32'(bus.tx_start), 32'd0);
            chk("rst_ovf", 32'(bus.ovf), 32'd0);
        end
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        tick();

        // 2. Single byte latency
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        chk("s_empty_k", 32'(bus.empty), 32'd0);
        chk("s_count_k", 32'(bus.count), 32'd1);
        chk("s_start_k", 32'(bus.tx_start), 32'd0);
        tick();
        chk("s_start_k1", 32'(bus.tx_start), 32'd0);
        chk("s_busy_k1", 32'(bus.busy), 32'd1);
        tick();
        chk("s_start_k2", 32'(bus.tx_start), 32'd1);
        chk("s_data_k2", 32'(bus.tx_data), 32'hA5);
        chk("s_count_k2", 32'(bus.count), 32'd0);
        tick();
        tick();
        chk("s_start_hold", 32'(bus.tx_start), 32'd1);
        pulse_done();
        chk("s_start_gap", 32'(bus.tx_start), 32'd0);
        chk("s_busy_gap", 32'(bus.busy), 32'd1);
        tick();
        chk("s_busy_idle", 32'(bus.busy), 32'd0);
        chk("s_count_end", 32'(bus.count), 32'd0);

        // 3. Burst to full, overflow, drain
        bus.wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'(i);
            tick();
        end
        chk("b_count15", 32'(bus.count), 32'd15);
        chk("b_full0", 32'(bus.full), 32'd0);
        chk("b_first", 32'(bus.tx_data), 32'h00);
        chk("b_start", 32'(bus.tx_start), 32'd1);
        bus.wr_data = 8'h10;
        tick();
        chk("b_count16", 32'(bus.count), 32'd16);
        chk("b_full1", 32'(bus.full), 32'd1);
        chk("b_ovf0", 32'(bus.ovf), 32'd0);
        bus.wr_data = 8'h11;
        tick();
        bus.wr_en = 1'b0;
        chk("b_ovf1", 32'(bus.ovf), 32'd1);
        chk("b_count_drop", 32'(bus.count), 32'd16);
        for (int n = 1; n <= 16; n++) begin
            pulse_done();
            chk("b_gap", 32'(bus.tx_start), 32'd0);
            wait_start("b_wait");
            chk("b_seq", 32'(bus.tx_data), 32'(n));
        end
        chk("b_drained", 32'(bus.count), 32'd0);
        pulse_done();
        repeat (4) tick();
        chk("b_no_extra", 32'(bus.tx_start), 32'd0);
        chk("b_busy_end", 32'(bus.busy), 32'd0);
        chk("b_ovf_sticky", 32'(bus.ovf), 32'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("b_ovf_clr", 32'(bus.ovf), 32'd0);

        // 5. Dropped write coinciding with a pop; clear vs set priority
        bus.wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_data = 8'h20 + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("c_full", 32'(bus.full), 32'd1);
        chk("c_data20", 32'(bus.tx_data), 32'h20);
        pulse_done();
        tick();
        tick();
        chk("c_load_count", 32'(bus.count), 32'd16);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        chk("c_pop_drop", 32'(bus.count), 32'd15);
        chk("c_ovf_set", 32'(bus.ovf), 32'd1);
        chk("c_data21", 32'(bus.tx_data), 32'h21);
        bus.wr_data = 8'hEF;
        tick();
        chk("c_refill", 32'(bus.count), 32'd16);
        bus.wr_data = 8'hF0;
        bus.clr_ovf = 1'b1;
        tick();
        chk("c_set_wins", 32'(bus.ovf), 32'd1);
        chk("c_count_keep", 32'(bus.count), 32'd16);
        bus.wr_en = 1'b0;
        tick();
        bus.clr_ovf = 1'b0;
        chk("c_clr_alone", 32'(bus.ovf), 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 4. Wrap-around: 8 bursts of 5 bytes
        for (int b = 0; b < 8; b++) begin
            bus.wr_en = 1'b1;
            for (int i = 0; i < 5; i++) begin
                bus.wr_data = 8'h40 + 8'((b * 5 + i) * 3);
                tick();
            end
            bus.wr_en = 1'b0;
            for (int i = 0; i < 5; i++) begin
                exp_b = 8'h40 + 8'((b * 5 + i) * 3);
                wait_start("w_wait");
                chk("w_order", 32'(bus.tx_data), 32'(exp_b));
                pulse_done();
            end
        end
        repeat (3) tick();
        chk("w_count0", 32'(bus.count), 32'd0);
        chk("w_empty", 32'(bus.empty), 32'd1);
        chk("w_busy", 32'(bus.busy), 32'd0);

        // 6. Reset mid-frame, then tx_done while idle
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 8'hC0 + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("r_count4", 32'(bus.count), 32'd4);
        chk("r_sending", 32'(bus.tx_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_start", 32'(bus.tx_start), 32'd0);
        chk("r_async_count", 32'(bus.count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_rel_count", 32'(bus.count), 32'd0);
        chk("r_rel_empty", 32'(bus.empty), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        tick();
        bus.tx_done = 1'b0;
        tick();
        chk("r_spur_count", 32'(bus.count), 32'd0);
        chk("r_spur_start", 32'(bus.tx_start), 32'd0);
        chk("r_spur_data", 32'(bus.tx_data), 32'd0);
        chk("r_spur_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
